pipe4_issue_ctrl: RTL and testbench
===================================

# pipe4_issue_ctrl

Issue controller for the 4-stage register/ALU/memory pipe. It buffers incoming instructions in a small queue and checks every source operand against a destination scoreboard. It issues one instruction per cycle when there is no read-after-write hazard and inserts bubbles (`iss_valid`=0) otherwise. It sits between the instruction source and the pipe's stage-1 inputs (`rs1`, `rs2`, `rd`, `func`, `addr`), so dependent instructions never read stale register-bank values.

## Interface
- `DEPTH`, 4: instruction queue entries; power of two, ≥2.
- `WB_LAT`, 2: number of cycles after the issue edge during which the issued `rd` is not yet readable from the register bank.
- `clk1`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: an instruction is offered.
- `in_ready`  out  1: the queue can accept; equals `!full`.
- `in_rs1`, `in_rs2`, `in_rd`, `in_func`  in  4 each: instruction fields.
- `in_addr`  in  8: memory address field.
- `flush`  in  1: synchronous queue clear.
- `iss_valid`  out  1: the issue bus holds a new instruction this cycle.
- `iss_rs1`, `iss_rs2`, `iss_rd`, `iss_func`  out  4 each: registered issue fields.
- `iss_addr`  out  8: registered address field.
- `illegal`  out  1: one-cycle pulse when an instruction with `func` ≥ 12 is discarded.
- `stall`  out  1: the queue is non-empty and its head is blocked by a hazard.
- `busy`  out  1: the queue is non-empty or any scoreboard entry is valid.
- `count`  out  $clog2(DEPTH)+1: current queue occupancy.

## Operation
- **Queue.** An instruction is pushed when `in_valid && in_ready`. There is no push when full, even if a pop occurs in the same cycle. Pointers wrap modulo `DEPTH`.
- **Source use by `func`:**
  - 0, 1, 2, 5, 6, 7 read rs1 and rs2.
  - 3, 8, 10, 11 read rs1 only.
  - 4, 9 read rs2 only.
  - 12–15 are illegal.
- **Scoreboard.** A `WB_LAT`-entry shift register of {valid, rd} that shifts every cycle.
  - On an issue edge, {1, `rd`} enters the head.
  - Otherwise {0, x} enters the head.
- **Hazard.** The head is blocked when any valid scoreboard entry's rd equals a source register that the head's `func` uses. rd never blocks rd: there is no WAW check, because writeback is in order.
- **Per-cycle decision, with head = queue head:**
  - Queue empty: no issue.
  - Head `func` illegal: pop the head, pulse `illegal`, no issue, no scoreboard insert.
  - Head hazard-free: pop, register the fields onto `iss_*`, `iss_valid`=1.
  - Otherwise: keep the head, `iss_valid`=0, `stall`=1.
- **FSM states:**
  - IDLE: queue empty.
  - RUN: head issuable or illegal.
  - STALL: head blocked.
- **FSM transitions:**
  - IDLE→RUN on the first push.
  - RUN→STALL when the new head is blocked.
  - STALL→RUN when the blocking entry ages out.
  - Any state→IDLE when the queue empties.
- **Flush.**
  - Clears the queue pointers and count, and forces IDLE.
  - No issue occurs in the flush cycle.
  - Scoreboard entries keep aging, because those instructions are already in flight.
  - A push in the same cycle as `flush` is dropped.
- **Reset.** Every output register goes to 0: `iss_*`, `iss_valid`, `illegal`, `count`; `stall`=0, `busy`=0. Queue and scoreboard are invalidated and the FSM is IDLE. Reset mid-stall drops all queued instructions.

## Timing
- Latency: a push at edge n into an empty queue, hazard-free, produces `iss_valid`=1 after edge n+1.
- Throughput: one issue per cycle for independent instructions.
- Dependent producer/consumer:
  - Producer issued at edge n allows the consumer's earliest issue at edge n+WB_LAT+1.
  - With the default `WB_LAT`=2 this means exactly 2 bubble cycles.
- `in_ready`, `stall`, `busy` and `count` reflect the current registered state. `count` updates on the edge after a push or pop.
- `illegal` is high for exactly the one cycle following the discard edge.

## Configuration
- `PIPE4_ISSUE_STATS_EN`
  - Defined: adds outputs `issued_cnt` (32) and `stall_cnt` (32).
    - `issued_cnt` increments on each issue.
    - `stall_cnt` increments each cycle `stall`=1.
    - Both saturate at all-ones, clear on `reset`, and are unaffected by `flush`.
  - Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `pipe4_pkg` holds:
  - the `func` enum (ADD=0 … SHL=11);
  - a constant `FUNC_LAST`=11;
  - an `instr_t` struct {rs1, rs2, rd, func, addr};
  - a function `uses_rs1`/`uses_rs2(func)`.
- One sub-module, `pipe4_instr_fifo`, implements the `DEPTH`-entry queue of `instr_t` with full, empty and count.
- The scoreboard, hazard check and FSM live in the top module.

## Test plan
- Independent stream A{1,2,→3,ADD}, B{4,5,→6,SUB}, pushed on consecutive edges from reset → issued on consecutive edges, `stall` never 1.
- A{1,2,→3,ADD} then B{3,4,→5,AND} → B issues exactly 3 edges after A; `stall`=1 for 2 cycles; `stall_cnt`=2 when stats are enabled.
- Head {7,3,→8,func=3 (pass A)} with rd 3 in flight → no stall, because rs2 is unused for func 3; issue on the next edge.
- Push 5 instructions while the head is stalled, `DEPTH`=4 → `in_ready`=0 once `count`=4; the 5th is accepted only after the first pop.
- Instruction with `func`=13 → not issued, `illegal` pulses for 1 cycle, `count` decrements, and the next instruction issues the following cycle.
- `flush` asserted while `count`=3 and `stall`=1, then `reset` asserted asynchronously mid-cycle → `count`=0 and IDLE after the flush edge; after reset, all outputs are 0 immediately and `busy`=0.

Source files
------------

// File: rtl/pipe4_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe4_pkg
// Desc   : Shared instruction types, func decode helpers and FSM encoding
//          for the pipe4 issue controller.
// Rev    : 1.0 - initial release
// ============================================================================
package pipe4_pkg;

    typedef enum logic [3:0] {
        FN_ADD   = 4'd0,
        FN_SUB   = 4'd1,
        FN_AND   = 4'd2,
        FN_PASSA = 4'd3,
        FN_PASSB = 4'd4,
        FN_OR    = 4'd5,
        FN_XOR   = 4'd6,
        FN_CMP   = 4'd7,
        FN_LOAD  = 4'd8,
        FN_STORE = 4'd9,
        FN_NOT   = 4'd10,
        FN_SHL   = 4'd11
    } func_e;

    localparam logic [3:0] FUNC_LAST = 4'd11;

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } instr_t;

    // Only the fields that take part in the hazard check.
    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] func;
    } src_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_e;

    function automatic logic uses_rs1(input logic [3:0] func);
        case (func)
            FN_ADD, FN_SUB, FN_AND, FN_PASSA, FN_OR, FN_XOR, FN_CMP,
            FN_LOAD, FN_NOT, FN_SHL: uses_rs1 = 1'b1;
            default:                 uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [3:0] func);
        case (func)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_CMP,
            FN_PASSB, FN_STORE: uses_rs2 = 1'b1;
            default:            uses_rs2 = 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [3:0] func);
        return func > FUNC_LAST;
    endfunction

    function automatic logic reads_reg(input src_t s, input logic [3:0] rd);
        return (uses_rs1(s.func) && (s.rs1 == rd)) ||
               (uses_rs2(s.func) && (s.rs2 == rd));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe4_instr_fifo.sv
`default_nettype none
// ============================================================================
// Module : pipe4_instr_fifo
// Desc   : DEPTH-entry instruction queue with occupancy and next-head lookahead.
// Rev    : 1.0 - initial release
// ============================================================================
module pipe4_instr_fifo
    import pipe4_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk1,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    input  instr_t                  wdata_i,
    output instr_t                  head_o,
    output src_t                    head_nx_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [$clog2(DEPTH):0]  count_nx_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    instr_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            w_push, w_pop, w_nx_is_new;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign w_push  = push_i && !full_o && !flush_i;
    assign w_pop   = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(w_push);
        rd_ptr_d = rd_ptr_q + AW'(w_pop);
        count_d  = count_q + CW'(w_push) - CW'(w_pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk1) begin
        if (w_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // The next head is the word being written when the queue would otherwise drain.
    assign w_nx_is_new = w_push && (rd_ptr_d == wr_ptr_q);

    always_comb begin
        if (w_nx_is_new)
            head_nx_o = {wdata_i.rs1, wdata_i.rs2, wdata_i.func};
        else
            head_nx_o = {mem_q[rd_ptr_d].rs1, mem_q[rd_ptr_d].rs2, mem_q[rd_ptr_d].func};
    end

    assign head_o     = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign count_nx_o = count_d;

endmodule
`default_nettype wire

// File: rtl/pipe4_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipe4_issue_ctrl
// Desc   : Queued in-order issue with a WB_LAT-deep destination scoreboard.
//          Define PIPE4_ISSUE_STATS_EN to add issued_cnt / stall_cnt outputs.
// Rev    : 1.0 - initial release
// ============================================================================
module pipe4_issue_ctrl
    import pipe4_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WB_LAT = 2
) (
    input  logic                    clk1,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_rs1,
    input  logic [3:0]              in_rs2,
    input  logic [3:0]              in_rd,
    input  logic [3:0]              in_func,
    input  logic [7:0]              in_addr,
    input  logic                    flush,
    output logic                    iss_valid,
    output logic [3:0]              iss_rs1,
    output logic [3:0]              iss_rs2,
    output logic [3:0]              iss_rd,
    output logic [3:0]              iss_func,
    output logic [7:0]              iss_addr,
    output logic                    illegal,
    output logic                    stall,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  count
`ifdef PIPE4_ISSUE_STATS_EN
    ,
    output logic [31:0]             issued_cnt,
    output logic [31:0]             stall_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    instr_t             w_wdata, w_head, iss_q;
    src_t               w_head_nx;
    logic               w_full, w_empty, w_push, w_pop, w_issue, w_discard;
    logic               w_hazard, w_hazard_nx;
    logic [CW-1:0]      w_count, w_count_nx;
    logic [WB_LAT-1:0]  sb_vld_q, sb_vld_d;
    logic [3:0]         sb_rd_q [WB_LAT];
    logic [3:0]         sb_rd_d [WB_LAT];
    state_e             state_q, state_d;
    logic               iss_valid_q, illegal_q;

    assign w_wdata = {in_rs1, in_rs2, in_rd, in_func, in_addr};

    pipe4_instr_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk1       (clk1),
        .reset      (reset),
        .push_i     (w_push),
        .pop_i      (w_pop),
        .flush_i    (flush),
        .wdata_i    (w_wdata),
        .head_o     (w_head),
        .head_nx_o  (w_head_nx),
        .full_o     (w_full),
        .empty_o    (w_empty),
        .count_o    (w_count),
        .count_nx_o (w_count_nx)
    );

    always_comb begin
        w_push    = in_valid && !w_full && !flush;
        w_discard = !w_empty && !flush && is_illegal(w_head.func);
        w_issue   = !w_empty && !flush && !is_illegal(w_head.func) && !w_hazard;
        w_pop     = w_issue || w_discard;
    end

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < WB_LAT; i++) begin
            if (sb_vld_q[i] && reads_reg({w_head.rs1, w_head.rs2, w_head.func}, sb_rd_q[i]))
                w_hazard = 1'b1;
        end
    end

    always_comb begin
        sb_vld_d[0] = w_issue;
        sb_rd_d[0]  = w_issue ? w_head.rd : 4'd0;
        for (int i = 1; i < WB_LAT; i++) begin
            sb_vld_d[i] = sb_vld_q[i-1];
            sb_rd_d[i]  = sb_rd_q[i-1];
        end
    end

    // Lookahead so the registered state already describes the head seen next cycle.
    always_comb begin
        w_hazard_nx = 1'b0;
        for (int i = 0; i < WB_LAT; i++) begin
            if (sb_vld_d[i] && reads_reg(w_head_nx, sb_rd_d[i]))
                w_hazard_nx = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush || (w_count_nx == '0))
            state_d = ST_IDLE;
        else if (w_hazard_nx && !is_illegal(w_head_nx.func))
            state_d = ST_STALL;
        else
            state_d = ST_RUN;
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sb_vld_q    <= '0;
            for (int i = 0; i < WB_LAT; i++) sb_rd_q[i] <= 4'd0;
            iss_q       <= '0;
            iss_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sb_vld_q    <= sb_vld_d;
            for (int i = 0; i < WB_LAT; i++) sb_rd_q[i] <= sb_rd_d[i];
            iss_valid_q <= w_issue;
            illegal_q   <= w_discard;
            if (w_issue) iss_q <= w_head;
        end
    end

    assign in_ready  = !w_full;
    assign iss_valid = iss_valid_q;
    assign iss_rs1   = iss_q.rs1;
    assign iss_rs2   = iss_q.rs2;
    assign iss_rd    = iss_q.rd;
    assign iss_func  = iss_q.func;
    assign iss_addr  = iss_q.addr;
    assign illegal   = illegal_q;
    assign stall     = (state_q == ST_STALL);
    assign busy      = !w_empty || (|sb_vld_q);
    assign count     = w_count;

`ifdef PIPE4_ISSUE_STATS_EN
    logic [31:0] issued_cnt_q, stall_cnt_q;

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            issued_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (w_issue && (issued_cnt_q != '1)) issued_cnt_q <= issued_cnt_q + 32'd1;
            if (stall && (stall_cnt_q != '1))    stall_cnt_q  <= stall_cnt_q + 32'd1;
        end
    end

    assign issued_cnt = issued_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe4_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe4_issue_ctrl
// Desc   : Directed self-checking bench for pipe4_issue_ctrl with an issue scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_pipe4_issue_ctrl;

    logic       clk1 = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0, in_func = '0;
    logic [7:0] in_addr = '0;
    logic       in_ready, iss_valid, illegal, stall, busy;
    logic [3:0] iss_rs1, iss_rs2, iss_rd, iss_func;
    logic [7:0] iss_addr;
    logic [2:0] count;
`ifdef PIPE4_ISSUE_STATS_EN
    logic [31:0] issued_cnt, stall_cnt;
    logic [31:0] stall_base;
`endif

    int         checks = 0;
    int         errors = 0;
    int         n_exp  = 0;
    logic [23:0] exp_q [$];

    always #5 clk1 = ~clk1;

    pipe4_issue_ctrl #(.DEPTH(4), .WB_LAT(2)) dut (
        .clk1       (clk1),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_func    (in_func),
        .in_addr    (in_addr),
        .flush      (flush),
        .iss_valid  (iss_valid),
        .iss_rs1    (iss_rs1),
        .iss_rs2    (iss_rs2),
        .iss_rd     (iss_rd),
        .iss_func   (iss_func),
        .iss_addr   (iss_addr),
        .illegal    (illegal),
        .stall      (stall),
        .busy       (busy),
        .count      (count)
`ifdef PIPE4_ISSUE_STATS_EN
        ,
        .issued_cnt (issued_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then retire any issue against the scoreboard queue.
    task automatic tick();
        @(posedge clk1);
        #1;
        if (iss_valid === 1'b1) begin
            if (exp_q.size() == 0)
                chk("spurious_issue", 32'(iss_valid), 32'd0);
            else
                chk("iss_fields", {8'h0, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr},
                    {8'h0, exp_q.pop_front()});
        end
    endtask

    task automatic drive(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                         input logic [3:0] func, input logic [7:0] addr, input bit exp_iss);
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        in_func  = func;
        in_addr  = addr;
        in_valid = 1'b1;
        if (exp_iss) begin
            exp_q.push_back({rs1, rs2, rd, func, addr});
            n_exp++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(posedge clk1);
        @(posedge clk1);
        #3;
        reset = 1'b0;
        chk("rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("rst_iss_bus", {8'h0, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE4_ISSUE_STATS_EN
        chk("rst_issued_cnt", issued_cnt, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif

        // Independent stream: back-to-back issue, no stall
        drive(4'd1, 4'd2, 4'd3, 4'd0, 8'h10, 1'b1);
        tick();
        chk("ind_count1", 32'(count), 32'd1);
        chk("ind_noiss_yet", 32'(iss_valid), 32'd0);
        drive(4'd4, 4'd5, 4'd6, 4'd1, 8'h20, 1'b1);
        tick();
        chk("ind_A_valid", 32'(iss_valid), 32'd1);
        chk("ind_A_stall", 32'(stall), 32'd0);
        chk("ind_count2", 32'(count), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("ind_B_valid", 32'(iss_valid), 32'd1);
        chk("ind_B_stall", 32'(stall), 32'd0);
        chk("ind_count3", 32'(count), 32'd0);
        repeat (3) tick();
        chk("ind_idle_busy", 32'(busy), 32'd0);

        // Producer/consumer RAW: two bubbles
`ifdef PIPE4_ISSUE_STATS_EN
        stall_base = stall_cnt;
`endif
        drive(4'd1, 4'd2, 4'd3, 4'd0, 8'h30, 1'b1);
        tick();
        drive(4'd3, 4'd4, 4'd5, 4'd2, 8'h31, 1'b1);
        tick();
        chk("raw_A_valid", 32'(iss_valid), 32'd1);
        chk("raw_stall1", 32'(stall), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("raw_bubble1", 32'(iss_valid), 32'd0);
        chk("raw_stall2", 32'(stall), 32'd1);
        tick();
        chk("raw_bubble2", 32'(iss_valid), 32'd0);
        chk("raw_stall_end", 32'(stall), 32'd0);
        tick();
        chk("raw_B_valid", 32'(iss_valid), 32'd1);
`ifdef PIPE4_ISSUE_STATS_EN
        chk("raw_stall_cnt", stall_cnt - stall_base, 32'd2);
`endif
        repeat (3) tick();

        // Unused rs2 does not block (func 3 reads rs1 only)
        drive(4'd1, 4'd2, 4'd3, 4'd0, 8'h40, 1'b1);
        tick();
        drive(4'd7, 4'd3, 4'd8, 4'd3, 8'h41, 1'b1);
        tick();
        chk("pa_P_valid", 32'(iss_valid), 32'd1);
        chk("pa_no_stall", 32'(stall), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("pa_Q_valid", 32'(iss_valid), 32'd1);
        repeat (3) tick();

        // Fill to DEPTH with a dependent chain
        for (int k = 0; k < 6; k++) begin
            drive(4'(k), 4'(k), 4'(k + 1), 4'd0, 8'(8'h50 + k), 1'b1);
            tick();
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_stall", 32'(stall), 32'd1);
        drive(4'd6, 4'd6, 4'd7, 4'd0, 8'h56, 1'b1);
        tick();
        chk("full_reject_count", 32'(count), 32'd4);
        tick();
        chk("full_pop_no_push", 32'(count), 32'd3);
        chk("full_ready_again", 32'(in_ready), 32'd1);
        tick();
        chk("full_accept5", 32'(count), 32'd4);
        in_valid = 1'b0;
        repeat (20) tick();
        chk("full_drain_count", 32'(count), 32'd0);
        chk("full_drain_busy", 32'(busy), 32'd0);

        // Illegal func discard
        drive(4'd1, 4'd1, 4'd1, 4'd13, 8'h60, 1'b0);
        tick();
        chk("ill_count1", 32'(count), 32'd1);
        chk("ill_pre", 32'(illegal), 32'd0);
        drive(4'd2, 4'd2, 4'd7, 4'd0, 8'h61, 1'b1);
        tick();
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_noiss", 32'(iss_valid), 32'd0);
        chk("ill_count2", 32'(count), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("ill_pulse_end", 32'(illegal), 32'd0);
        chk("ill_next_iss", 32'(iss_valid), 32'd1);
        chk("ill_count3", 32'(count), 32'd0);
        drive(4'd1, 4'd2, 4'd3, 4'd15, 8'h62, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("ill2_pulse", 32'(illegal), 32'd1);
        chk("ill2_count_dec", 32'(count), 32'd0);
        tick();
        chk("ill2_pulse_end", 32'(illegal), 32'd0);
        repeat (3) tick();

        // Flush while stalled with three queued
        for (int k = 0; k < 5; k++) begin
            drive(4'(k), 4'(k), 4'(k + 1), 4'd0, 8'(8'h70 + k), k < 2);
            tick();
        end
        chk("fl_pre_count", 32'(count), 32'd3);
        chk("fl_pre_stall", 32'(stall), 32'd1);
        flush = 1'b1;
        drive(4'd9, 4'd9, 4'd9, 4'd0, 8'h7f, 1'b0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_stall", 32'(stall), 32'd0);
        chk("fl_noiss", 32'(iss_valid), 32'd0);
        chk("fl_busy_inflight", 32'(busy), 32'd1);
        tick();
        chk("fl_dropped_push", 32'(count), 32'd0);
        repeat (3) tick();
        chk("fl_busy_end", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a stall
        drive(4'd1, 4'd1, 4'd3, 4'd0, 8'h80, 1'b1);
        tick();
        drive(4'd3, 4'd3, 4'd4, 4'd0, 8'h81, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("ar_stall", 32'(stall), 32'd1);
`ifdef PIPE4_ISSUE_STATS_EN
        chk("ar_issued_cnt", issued_cnt, 32'(n_exp));
`endif
        #3;
        reset = 1'b1;
        #1;
        chk("ar_iss_valid", 32'(iss_valid), 32'd0);
        chk("ar_iss_bus", {8'h0, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}, 32'd0);
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_stall0", 32'(stall), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_illegal", 32'(illegal), 32'd0);
`ifdef PIPE4_ISSUE_STATS_EN
        chk("ar_stats_clr", issued_cnt | stall_cnt, 32'd0);
`endif
        #1;
        reset = 1'b0;
        repeat (5) tick();
        chk("ar_post_noiss", 32'(iss_valid), 32'd0);
        chk("ar_post_busy", 32'(busy), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
